// File: rtl/aldffe_stim_pkg.sv
// Shared types and constants for the aldffe stimulus sequencer.
package aldffe_stim_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SETTLE = 3'd2,
    PULSE  = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Drive program, indexed by step (bit/element i = step i).
  localparam logic [7:0]      EN_TAB = 8'b0000_1111;
  localparam logic [7:0][1:0] D_TAB  = {2'b11, 2'b10, 2'b01, 2'b00,
                                        2'b11, 2'b10, 2'b01, 2'b00};
  localparam logic [7:0][1:0] AD_TAB = {2'b00, 2'b01, 2'b01, 2'b11,
                                        2'b00, 2'b01, 2'b01, 2'b11};
  localparam logic [2:0]      LAST_STEP = 3'd7;

  // Field index of each taint label in vec_data; bit offset = field*TAINT_W.
  localparam int AD_T_FIELD    = 3;
  localparam int ALOAD_T_FIELD = 2;
  localparam int D_T_FIELD     = 1;
  localparam int EN_T_FIELD    = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/aldffe_phase_timer.sv
// Loadable down-counter timing one FSM phase; expire marks the phase's last cycle.
module aldffe_phase_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expire
);

  logic [CW-1:0] cnt;

  // Reload on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - CW'(1);
  end

  assign expire = (cnt == CW'(1));

endmodule

// File: rtl/aldffe_stim_seq.sv
// Stimulus sequencer: accepts a taint vector, then replays the 8-step
// en/d/ad/aload program toward the async-load flop under test.
module aldffe_stim_seq
  import aldffe_stim_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int TAINT_W    = 32,
  parameter int SETTLE_CYC = 2,
  parameter int PULSE_CYC  = 1,
  parameter int HOLD_CYC   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic [4*TAINT_W-1:0] vec_data,
  input  logic                 abort,
  output logic [WIDTH-1:0]     d,
  output logic [WIDTH-1:0]     ad,
  output logic                 en,
  output logic                 aload,
  output logic [TAINT_W-1:0]   d_t,
  output logic [TAINT_W-1:0]   ad_t,
  output logic [TAINT_W-1:0]   en_t,
  output logic [TAINT_W-1:0]   aload_t,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          vec_cnt
);

  localparam int CW = $clog2(max3(SETTLE_CYC, PULSE_CYC, HOLD_CYC)) + 1;

  state_t        state, state_nxt;
  logic [2:0]    step;
  logic          t_load, t_expire;
  logic [CW-1:0] t_val;
  logic          accept, kill;

  assign vec_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = vec_ready && vec_valid;
  assign kill      = abort && (state != IDLE);

  aldffe_phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .expire   (t_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; the timer is reloaded on every timed-phase entry.
  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_val     = '0;
    case (state)
      IDLE:   if (vec_valid) state_nxt = SETUP;
      SETUP: begin
        state_nxt = SETTLE;
        t_load    = 1'b1;
        t_val     = CW'(SETTLE_CYC);
      end
      SETTLE: if (t_expire) begin
        state_nxt = PULSE;
        t_load    = 1'b1;
        t_val     = CW'(PULSE_CYC);
      end
      PULSE:  if (t_expire) begin
        state_nxt = HOLD;
        t_load    = 1'b1;
        t_val     = CW'(HOLD_CYC);
      end
      HOLD:   if (t_expire) state_nxt = (step == LAST_STEP) ? DONE : SETUP;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // Registered outputs follow the current state, so each drive appears one
  // edge after the state that produces it (data after SETUP, aload after PULSE,
  // done after DONE). Abort clears aload/en on the same edge it idles the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d       <= '0;
      ad      <= '0;
      en      <= 1'b0;
      aload   <= 1'b0;
      d_t     <= '0;
      ad_t    <= '0;
      en_t    <= '0;
      aload_t <= '0;
      done    <= 1'b0;
      vec_cnt <= '0;
      step    <= '0;
    end else begin
      done  <= (state == DONE) && !kill;
      aload <= (state == PULSE) && !kill;
      if (accept) begin
        ad_t    <= vec_data[AD_T_FIELD*TAINT_W    +: TAINT_W];
        aload_t <= vec_data[ALOAD_T_FIELD*TAINT_W +: TAINT_W];
        d_t     <= vec_data[D_T_FIELD*TAINT_W     +: TAINT_W];
        en_t    <= vec_data[EN_T_FIELD*TAINT_W    +: TAINT_W];
        step    <= '0;
      end
      if (kill) begin
        en <= 1'b0;
      end else begin
        if (state == SETUP) begin
          en <= EN_TAB[step];
          d  <= WIDTH'(D_TAB[step]);
          ad <= WIDTH'(AD_TAB[step]);
        end
        if (state == HOLD && t_expire && step != LAST_STEP)
          step <= step + 3'd1;
        if (state == DONE)
          vec_cnt <= vec_cnt + 16'd1;
      end
    end
  end

endmodule
